mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
Parametrised N-input, W-bit-wide selector with registered output and a built-in channel sequencer.
- Manual mode: an external select picks the channel, as the existing combinational 16:1 tree does.
- Scan mode: an internal counter steps through every channel, holding each one for a programmable number of cycles, and flags each completed sweep.
- Sits between a bank of input sources and a single consumer, for example a display or serial path, that samples one channel at a time.

Parameters:
N_IN, 16, number of input channels (2..64, need not be a power of two)
W, 1, bits per channel
SEL_W, 4, select width; must satisfy 2**SEL_W >= N_IN
DWELL, 1, clock cycles each channel is held in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
w  input  N_IN*W  channel data; channel k occupies w[k*W+W-1 : k*W]
t  input  SEL_W  manual channel select
mode  input  1  0 = manual, 1 = scan
en  input  1  0 = hold all outputs and counters
f  output  W  registered selected channel data
sel_out  output  SEL_W  channel index that produced the current f
valid  output  1  f holds a legal channel's data
err  output  1  manual select >= N_IN was sampled
wrap  output  1  one-cycle pulse: scan sweep just presented channel N_IN-1 for the last dwell cycle

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; f=0, sel_out=0, valid=0, err=0, wrap=0; scan index=0; dwell count=0.
- State machine: IDLE, MANUAL, SCAN. Transitions are evaluated every clock edge.
  - en=0 from any state -> IDLE. In IDLE, f and sel_out hold their last values, valid=0, wrap=0.
  - en=1 and mode=0 -> MANUAL.
  - en=1 and mode=1 -> SCAN.
- MANUAL:
  - Each cycle: f <= channel t, sel_out <= t, valid <= 1, err <= 0. Latency is one clock from t/w to f.
  - If t >= N_IN: f <= 0, sel_out <= t, valid <= 0, err <= 1.
  - Scan index and dwell count are untouched.
- SCAN:
  - Entry from IDLE or MANUAL: scan index=0, dwell count=0. The first cycle in SCAN registers channel 0.
  - Each cycle: f <= channel[scan index], sel_out <= scan index, valid <= 1, err <= 0.
  - Dwell count increments each cycle. When it reaches DWELL-1 it clears and scan index advances.
  - Wrap-around: scan index N_IN-1 advances to 0, never to N_IN..2**SEL_W-1. wrap <= 1 in the same edge that registers the last dwell cycle of channel N_IN-1; otherwise wrap <= 0.
  - With DWELL=1, the index advances every cycle and wrap pulses every N_IN cycles.
- Simultaneous events:
  - mode and en changing on the same edge: en takes priority (en=0 -> IDLE).
  - Mode toggle SCAN->MANUAL->SCAN restarts the scan at channel 0.
  - en=0 mid-dwell followed by en=1 with mode still 1: the state passes through IDLE, so the scan restarts at channel 0.
- Data: w is sampled only at the registering edge; changes within a dwell period are reflected on the next cycle. No width conversion; f is exactly W bits.
- Reset asserted mid-scan clears all state immediately. On deassertion the first active edge behaves as entry from IDLE.

Decomposition:
- Shared package/header mux_scan_pkg: state encodings ST_IDLE=2'd0, ST_MANUAL=2'd1, ST_SCAN=2'd2; helper constant for the minimum SEL_W check.
- Sub-module mux_tree: purely combinational N_IN:1, W-bit selector taking w and a SEL_W select. Selects >= N_IN output 0. Built as a generate-loop tree of 4:1 stages.
- mux_scan contains the FSM, dwell counter, scan index, output registers and flags.

Test Plan:
1. N_IN=16, W=1, mode=0, en=1, w=16'hA5C3, t stepped 0..15 one per cycle -> f on the next cycle follows bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; valid=1; err=0.
2. N_IN=10, W=4, mode=0, t=12 -> next cycle f=0, valid=0, err=1, sel_out=12. Then t=9 -> f=channel 9, err=0.
3. N_IN=4, W=8, DWELL=3, mode=1, en=1, channels 8'h11/22/33/44 -> f=11,11,11,22,22,22,33,33,33,44,44,44,11... with wrap high only on the cycle f shows the third 44.
4. Scan at channel 2 mid-dwell, drop en for 2 cycles -> f held and valid=0. Re-raise en -> f=channel 0 the next cycle, dwell restarted.
5. resetn pulled low asynchronously between edges during scan -> f, sel_out, valid, err, wrap read 0 immediately. After release, the first edge with en=1, mode=1 yields channel 0.
6. DWELL=1, N_IN=16, scan for 48 cycles -> wrap pulses exactly 3 times, 16 cycles apart. sel_out never exceeds 15.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared FSM state encodings and elaboration-time helpers
// for the mux_scan selector and its mux_tree datapath.
package mux_scan_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  // Smallest select width able to address n channels.
  function automatic int min_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of 4:1 levels needed so that 4**levels >= n (at least one level).
  function automatic int tree_levels(input int n);
    int l;
    int cap;
    l   = 1;
    cap = 4;
    while (cap < n) begin
      l   = l + 1;
      cap = cap * 4;
    end
    return l;
  endfunction

endpackage

// File: rtl/mux_tree.sv
// mux_tree: combinational N_IN:1 selector, W bits per channel, built as a
// tree of 4:1 stages. Selects >= N_IN produce 0.
//   w   : packed channel data, channel k at w[k*W +: W]
//   sel : channel index
//   y   : selected channel (or 0 when sel is out of range)
module mux_tree
  import mux_scan_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4
) (
  input  logic [N_IN*W-1:0] w,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      y
);

  // Nodes are stored heap-style: node i has children 4i+1..4i+4, root is 0.
  // Leaf k then sits at FLEAF+k and its root-to-leaf path is k in base 4,
  // most significant digit first.
  localparam int LV    = tree_levels(N_IN);
  localparam int NLEAF = 4 ** LV;
  localparam int FLEAF = (NLEAF - 1) / 3;
  localparam int NN    = FLEAF + NLEAF;
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_IN);

  logic [W-1:0] node [NN];

  for (genvar j = 0; j < NLEAF; j++) begin : g_leaf
    if (j < N_IN) begin : g_ch
      assign node[FLEAF+j] = w[j*W +: W];
    end else begin : g_pad
      assign node[FLEAF+j] = '0;
    end
  end

  for (genvar d = 0; d < LV; d++) begin : g_lvl
    localparam int G = LV - 1 - d;          // select digit used at this depth
    localparam int F = ((4 ** d) - 1) / 3;  // first node index at this depth
    logic [1:0] dg;

    if (2*G+1 < SEL_W) begin : g_d2
      assign dg = sel[2*G+1 -: 2];
    end else if (2*G < SEL_W) begin : g_d1
      assign dg = {1'b0, sel[2*G]};
    end else begin : g_d0
      assign dg = 2'd0;
    end

    for (genvar j = 0; j < 4 ** d; j++) begin : g_node
      localparam int I = F + j;
      assign node[I] = dg[1] ? (dg[0] ? node[4*I+4] : node[4*I+3])
                             : (dg[0] ? node[4*I+2] : node[4*I+1]);
    end
  end

  // Padding leaves cover indices up to 4**LV-1; select bits above the tree
  // depth are caught here too.
  assign y = ({1'b0, sel} < N_LIM) ? node[0] : '0;

endmodule

// File: rtl/mux_scan.sv
// mux_scan: N_IN-input, W-bit selector with registered output and a
// channel sequencer.
//   clk, resetn : rising-edge clock, async active-low reset
//   w           : channel data, channel k at w[k*W +: W]
//   t           : manual channel select
//   mode        : 0 manual, 1 scan
//   en          : 0 holds f/sel_out and counters, drops valid
//   f, sel_out  : registered channel data and the index that produced it
//   valid       : f holds a legal channel's data
//   err         : last manual select was >= N_IN
//   wrap        : pulse on the last dwell cycle of channel N_IN-1 in scan
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_IN*W-1:0] w,
  input  logic [SEL_W-1:0]  t,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      f,
  output logic [SEL_W-1:0]  sel_out,
  output logic              valid,
  output logic              err,
  output logic              wrap
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0]   D_LAST = DCW'(DWELL - 1);
  localparam logic [SEL_W-1:0] I_LAST = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   N_LIM  = (SEL_W+1)'(N_IN);

  if (SEL_W < min_sel_w(N_IN)) begin : g_bad_sel_w
    $error("mux_scan: SEL_W too small for N_IN");
  end

  logic [1:0]       state, nstate;
  logic [SEL_W-1:0] idx, eidx, msel;
  logic [DCW-1:0]   dcnt, edcnt;
  logic [W-1:0]     mux_y;
  logic             t_ok, last_dwell, last_ch;

  always_comb begin
    nstate = ST_IDLE;
    if (en) nstate = mode ? ST_SCAN : ST_MANUAL;
  end

  // Any entry into SCAN (from IDLE or MANUAL) starts at channel 0, dwell 0;
  // the registered counters only carry over while already scanning.
  assign eidx       = (state == ST_SCAN) ? idx  : '0;
  assign edcnt      = (state == ST_SCAN) ? dcnt : '0;
  assign msel       = (nstate == ST_SCAN) ? eidx : t;
  assign t_ok       = ({1'b0, t} < N_LIM);
  assign last_dwell = (edcnt == D_LAST);
  assign last_ch    = (eidx == I_LAST);

  mux_tree #(.N_IN(N_IN), .W(W), .SEL_W(SEL_W)) u_tree (
    .w   (w),
    .sel (msel),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      f       <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      idx     <= '0;
      dcnt    <= '0;
    end else begin
      state <= nstate;
      case (nstate)
        ST_MANUAL: begin
          f       <= mux_y;   // tree returns 0 for out-of-range t
          sel_out <= t;
          valid   <= t_ok;
          err     <= !t_ok;
          wrap    <= 1'b0;
        end
        ST_SCAN: begin
          f       <= mux_y;
          sel_out <= eidx;
          valid   <= 1'b1;
          err     <= 1'b0;
          wrap    <= last_dwell && last_ch;
          if (last_dwell) begin
            dcnt <= '0;
            idx  <= last_ch ? '0 : eidx + SEL_W'(1);
          end else begin
            dcnt <= edcnt + DCW'(1);
            idx  <= eidx;
          end
        end
        default: begin
          // IDLE: f, sel_out, err and counters hold.
          valid <= 1'b0;
          wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: three configurations sharing clock, reset,
// mode and en. Expected results are queued when inputs are driven and
// compared one clock later.
module tb_mux_scan;

  typedef struct {
    int          dut;
    int          seq;
    logic [31:0] f;
    logic [31:0] sel;
    logic        valid;
    logic        err;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  logic resetn, mode, en;

  // A: 16 x 1, DWELL 1
  logic [15:0] wa;
  logic [3:0]  ta;
  logic        fa;
  logic [3:0]  sa;
  logic        va, ea, wra;
  // B: 10 x 4, DWELL 1
  logic [39:0] wb;
  logic [3:0]  tsb;
  logic [3:0]  fb;
  logic [3:0]  sb;
  logic        vb, eb, wrb;
  // C: 4 x 8, DWELL 3
  logic [31:0] wc;
  logic [1:0]  tc;
  logic [7:0]  fc;
  logic [1:0]  sc;
  logic        vc, ec, wrc;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mux_scan #(.N_IN(16), .W(1), .SEL_W(4), .DWELL(1)) u_a (
    .clk(clk), .resetn(resetn), .w(wa), .t(ta), .mode(mode), .en(en),
    .f(fa), .sel_out(sa), .valid(va), .err(ea), .wrap(wra));

  mux_scan #(.N_IN(10), .W(4), .SEL_W(4), .DWELL(1)) u_b (
    .clk(clk), .resetn(resetn), .w(wb), .t(tsb), .mode(mode), .en(en),
    .f(fb), .sel_out(sb), .valid(vb), .err(eb), .wrap(wrb));

  mux_scan #(.N_IN(4), .W(8), .SEL_W(2), .DWELL(3)) u_c (
    .clk(clk), .resetn(resetn), .w(wc), .t(tc), .mode(mode), .en(en),
    .f(fc), .sel_out(sc), .valid(vc), .err(ec), .wrap(wrc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input exp_t e);
    logic [31:0] of, os;
    logic        ov, oe, ow;
    string       nm;
    case (e.dut)
      0:       begin of = 32'(fa); os = 32'(sa); ov = va; oe = ea; ow = wra; nm = "A"; end
      1:       begin of = 32'(fb); os = 32'(sb); ov = vb; oe = eb; ow = wrb; nm = "B"; end
      default: begin of = 32'(fc); os = 32'(sc); ov = vc; oe = ec; ow = wrc; nm = "C"; end
    endcase
    chk($sformatf("%s%0d.f",     nm, e.seq), of, e.f);
    chk($sformatf("%s%0d.sel",   nm, e.seq), os, e.sel);
    chk($sformatf("%s%0d.valid", nm, e.seq), 32'(ov), 32'(e.valid));
    chk($sformatf("%s%0d.err",   nm, e.seq), 32'(oe), 32'(e.err));
    chk($sformatf("%s%0d.wrap",  nm, e.seq), 32'(ow), 32'(e.wrap));
  endtask

  task automatic push(input int d, input int s, input logic [31:0] f,
                      input logic [31:0] sel, input logic v, input logic e,
                      input logic w);
    exp_t x;
    x.dut = d; x.seq = s; x.f = f; x.sel = sel; x.valid = v; x.err = e; x.wrap = w;
    q.push_back(x);
  endtask

  // Advance one active edge and compare the oldest queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 0) begin
      chk("sb_empty", 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      cmp(e);
    end
  endtask

  task automatic zero_chk(input int d, input int s);
    exp_t z;
    z.dut = d; z.seq = s; z.f = '0; z.sel = '0; z.valid = 1'b0; z.err = 1'b0; z.wrap = 1'b0;
    cmp(z);
  endtask

  initial begin
    int ch, nw, lastw;
    resetn = 1'b0; en = 1'b0; mode = 1'b0;
    wa = '0; ta = '0; wb = '0; tsb = '0; wc = '0; tc = '0;
    #3;
    zero_chk(0, 0);
    zero_chk(1, 0);
    zero_chk(2, 0);
    @(negedge clk);
    resetn = 1'b1; en = 1'b1; mode = 1'b0;

    // Manual sweep of A over a fixed pattern.
    wa = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      ta = 4'(k);
      push(0, k, 32'(wa[k]), 32'(k), 1'b1, 1'b0, 1'b0);
      step();
    end

    // Out-of-range manual select on B, then a legal one.
    wb  = 40'({$urandom(), $urandom()});
    tsb = 4'd12;
    push(1, 0, 32'd0, 32'd12, 1'b0, 1'b1, 1'b0);
    step();
    tsb = 4'd9;
    push(1, 1, 32'(wb[39:36]), 32'd9, 1'b1, 1'b0, 1'b0);
    step();

    // Scan on C with DWELL 3; run into the middle of channel 2's second sweep.
    wc   = 32'h44332211;
    mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ch = (i / 3) % 4;
      push(2, i, 32'(8'h11 * (ch + 1)), 32'(ch), 1'b1, 1'b0, (i % 3 == 2) && (ch == 3));
      step();
    end

    // Drop en mid-dwell: outputs hold with valid low, then scan restarts.
    en = 1'b0;
    push(2, 20, 32'h33, 32'd2, 1'b0, 1'b0, 1'b0);
    step();
    push(2, 21, 32'h33, 32'd2, 1'b0, 1'b0, 1'b0);
    step();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ch = i / 3;
      push(2, 22 + i, 32'(8'h11 * (ch + 1)), 32'(ch), 1'b1, 1'b0, 1'b0);
      step();
    end

    // Asynchronous reset between edges while scanning.
    #2 resetn = 1'b0;
    #1;
    zero_chk(2, 30);
    zero_chk(0, 30);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ch = i / 3;
      push(2, 40 + i, 32'(8'h11 * (ch + 1)), 32'(ch), 1'b1, 1'b0, 1'b0);
      step();
    end

    // A scanning with DWELL 1 for three sweeps, fresh data every cycle.
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    nw = 0;
    lastw = 0;
    for (int i = 0; i < 48; i++) begin
      wa = 16'($urandom());
      push(0, 100 + i, 32'(wa[i % 16]), 32'(i % 16), 1'b1, 1'b0, (i % 16) == 15);
      step();
      if (wra) begin
        nw++;
        if (nw > 1) chk("wrap_gap", 32'(i - lastw), 32'd16);
        lastw = i;
      end
    end
    chk("wrap_cnt", 32'(nw), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
